// File: rtl/mem_arbiter_if.sv
// Requester and shared-memory signals of the instruction/data memory arbiter.
// master: the arbiter's view; slave: the requesters' and memory's view.
interface mem_arbiter_if;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic          i_req;
    logic [DW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ack;

    logic          d_ren;
    logic          d_wen;
    logic [DW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_sel;
    logic [DW-1:0] d_rdata;
    logic          d_ack;
    logic          err;

    logic [DW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [SW-1:0] bus_sel;
    logic          bus_ren;
    logic          bus_wen;
    logic [DW-1:0] bus_rdata;
    logic          bus_busy;

    modport master (
        input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, d_sel, bus_rdata, bus_busy,
        output i_rdata, i_ack, d_rdata, d_ack, err,
        output bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen
    );

    modport slave (
        output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, d_sel, bus_rdata, bus_busy,
        input  i_rdata, i_ack, d_rdata, d_ack, err,
        input  bus_addr, bus_wdata, bus_sel, bus_ren, bus_wen
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port arbiter sharing one memory bus between instruction fetch and data
// access, alternating on contention and aborting transactions that stall too long.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          nrst,
    mem_arbiter_if.master mif
);
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 4;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    state_t          state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            last_data_q, last_data_d;

    logic [DW-1:0]   bus_addr_d, bus_wdata_d, i_rdata_d, d_rdata_d;
    logic [SW-1:0]   bus_sel_d;
    logic            bus_ren_d, bus_wen_d, i_ack_d, d_ack_d, err_d;

    logic            i_pend_c, d_pend_c, grant_i_c, grant_d_c, done_c, abort_c;

    // A requester whose ack is high this cycle is still holding a finished request.
    assign i_pend_c  = mif.i_req & ~mif.i_ack;
    assign d_pend_c  = (mif.d_ren | mif.d_wen) & ~mif.d_ack;
    assign grant_i_c = (state_q == IDLE) & i_pend_c & (~d_pend_c | last_data_q);
    assign grant_d_c = (state_q == IDLE) & d_pend_c & (~i_pend_c | ~last_data_q);
    assign done_c    = (state_q != IDLE) & ~mif.bus_busy;
    assign abort_c   = (state_q != IDLE) & mif.bus_busy & (wait_cnt_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i_c)      state_d = FETCH;
                else if (grant_d_c) state_d = DATA;
            end
            FETCH, DATA: begin
                if (done_c | abort_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic bus_clr;
        bus_clr     = 1'b0;
        bus_addr_d  = mif.bus_addr;
        bus_wdata_d = mif.bus_wdata;
        bus_sel_d   = mif.bus_sel;
        bus_ren_d   = mif.bus_ren;
        bus_wen_d   = mif.bus_wen;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        i_rdata_d   = mif.i_rdata;
        d_rdata_d   = mif.d_rdata;
        wait_cnt_d  = wait_cnt_q;
        last_data_d = last_data_q;
        case (state_q)
            IDLE: begin
                if (grant_i_c) begin
                    bus_addr_d  = mif.i_addr;
                    bus_wdata_d = '0;
                    bus_sel_d   = {SW{1'b1}};
                    bus_ren_d   = 1'b1;
                    bus_wen_d   = 1'b0;
                    wait_cnt_d  = '0;
                    last_data_d = 1'b0;
                end else if (grant_d_c) begin
                    // Simultaneous load and store requests are served as a store.
                    bus_addr_d  = mif.d_addr;
                    bus_wdata_d = mif.d_wdata;
                    bus_sel_d   = mif.d_sel;
                    bus_ren_d   = mif.d_ren & ~mif.d_wen;
                    bus_wen_d   = mif.d_wen;
                    wait_cnt_d  = '0;
                    last_data_d = 1'b1;
                end else begin
                    bus_clr = 1'b1;
                end
            end
            FETCH: begin
                if (done_c | abort_c) begin
                    bus_clr   = 1'b1;
                    i_ack_d   = 1'b1;
                    err_d     = abort_c;
                    i_rdata_d = done_c ? mif.bus_rdata : '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (done_c | abort_c) begin
                    bus_clr   = 1'b1;
                    d_ack_d   = 1'b1;
                    err_d     = abort_c;
                    d_rdata_d = (done_c & ~mif.bus_wen) ? mif.bus_rdata : '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            default: bus_clr = 1'b1;
        endcase
        if (bus_clr) begin
            bus_addr_d  = '0;
            bus_wdata_d = '0;
            bus_sel_d   = '0;
            bus_ren_d   = 1'b0;
            bus_wen_d   = 1'b0;
        end
    end

    // Fetch wins the first contention after reset.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            mif.bus_addr  <= '0;
            mif.bus_wdata <= '0;
            mif.bus_sel   <= '0;
            mif.bus_ren   <= 1'b0;
            mif.bus_wen   <= 1'b0;
            mif.i_ack     <= 1'b0;
            mif.d_ack     <= 1'b0;
            mif.err       <= 1'b0;
            mif.i_rdata   <= '0;
            mif.d_rdata   <= '0;
            wait_cnt_q    <= '0;
            last_data_q   <= 1'b1;
        end else begin
            mif.bus_addr  <= bus_addr_d;
            mif.bus_wdata <= bus_wdata_d;
            mif.bus_sel   <= bus_sel_d;
            mif.bus_ren   <= bus_ren_d;
            mif.bus_wen   <= bus_wen_d;
            mif.i_ack     <= i_ack_d;
            mif.d_ack     <= d_ack_d;
            mif.err       <= err_d;
            mif.i_rdata   <= i_rdata_d;
            mif.d_rdata   <= d_rdata_d;
            wait_cnt_q    <= wait_cnt_d;
            last_data_q   <= last_data_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random fetch/data traffic against
// a wait-state memory, with expected responses queued per requester and checked on ack.
module tb_mem_arbiter;
    localparam int unsigned TO = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    mem_arbiter_if mif();
    mem_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .nrst(nrst), .mif(mif));

    always #5 clk = ~clk;

    int   vectors     = 0;
    int   miscompares = 0;
    bit   rand_on     = 1'b0;
    bit   auto_mem    = 1'b0;
    logic        dir_busy  = 1'b0;
    logic [31:0] dir_rdata = '0;
    logic        mem_busy  = 1'b0;
    logic [31:0] mem_rdata = '0;
    bit   tb_last_data = 1'b1;

    exp_t i_q[$];
    exp_t d_q[$];
    logic [31:0] mem    [logic [31:0]];
    logic [31:0] dmodel [logic [31:0]];

    assign mif.bus_busy  = auto_mem ? mem_busy  : dir_busy;
    assign mif.bus_rdata = auto_mem ? mem_rdata : dir_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event occurred but was not allowed", name);
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory wait states are a fixed function of the address.
    function automatic int unsigned waits_of(input logic [31:0] a);
        return (a >> 2) % 32'd7;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Wait-state memory: busy for waits_of(addr) cycles, write lands on completion.
    initial begin : responder
        bit act, act_prev, busy_prev, is_f;
        int unsigned rem, held, exp_held;
        logic [31:0] la, lw, cur;
        logic [3:0]  ls;
        logic        lwen;
        act_prev = 1'b0; busy_prev = 1'b0; rem = 0; held = 0;
        la = '0; lw = '0; ls = '0; lwen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!auto_mem) begin
                act_prev     = 1'b0;
                tb_last_data = 1'b1;
            end else begin
                act = mif.bus_ren | mif.bus_wen;
                if (act_prev && !act) begin
                    if (!busy_prev && lwen) begin
                        cur = mem_rd(la);
                        for (int b = 0; b < 4; b++)
                            if (ls[b]) cur[8*b +: 8] = lw[8*b +: 8];
                        mem[la] = cur;
                    end
                    exp_held = (waits_of(la) >= TO) ? TO : waits_of(la) + 1;
                    check("bus_hold_cycles", 64'(held), 64'(exp_held));
                end
                if (act && !act_prev) begin
                    la = mif.bus_addr; lw = mif.bus_wdata; ls = mif.bus_sel; lwen = mif.bus_wen;
                    rem  = waits_of(la);
                    held = 1;
                    is_f = (la < 32'h1000);
                    if (is_f)
                        check("fetch_grant_bus", {mif.i_req, mif.bus_addr, mif.bus_sel, mif.bus_ren, mif.bus_wen},
                              {1'b1, mif.i_addr, 4'hF, 1'b1, 1'b0});
                    else begin
                        check("data_grant_bus", {mif.bus_addr, mif.bus_sel, mif.bus_ren, mif.bus_wen},
                              {mif.d_addr, mif.d_sel, mif.d_ren & ~mif.d_wen, mif.d_wen});
                        if (mif.d_wen) check("data_grant_wdata", 64'(mif.bus_wdata), 64'(mif.d_wdata));
                    end
                    if (mif.i_req && (mif.d_ren || mif.d_wen))
                        check("fair_grant_is_fetch", 64'(is_f), 64'(tb_last_data));
                    tb_last_data = !is_f;
                end else if (act) begin
                    held++;
                    if (rem > 0) rem--;
                end
                mem_busy  = act ? (rem > 0) : 1'($urandom);
                mem_rdata = act ? mem_rd(mif.bus_addr) : $urandom;
                act_prev  = act;
                busy_prev = act && (rem > 0);
            end
        end
    end

    // Scoreboard: pop the oldest expected response whenever an ack is presented.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rand_on) begin
            if (mif.i_ack) begin
                if (i_q.size() == 0) fail("i_ack_unexpected");
                else begin
                    e = i_q.pop_front();
                    check("i_rdata", 64'(mif.i_rdata), 64'(e.rdata));
                    check("i_err", 64'(mif.err), 64'(e.err));
                end
            end
            if (mif.d_ack) begin
                if (d_q.size() == 0) fail("d_ack_unexpected");
                else begin
                    e = d_q.pop_front();
                    check("d_rdata", 64'(mif.d_rdata), 64'(e.rdata));
                    check("d_err", 64'(mif.err), 64'(e.err));
                end
            end
            if (mif.i_ack && mif.d_ack) fail("dual_ack");
            if (mif.err && !mif.i_ack && !mif.d_ack) fail("err_without_ack");
        end
    end

    task automatic fetch_agent(input int n);
        logic [31:0] a;
        exp_t e;
        bit got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            a = 32'($urandom_range(0, 1023)) << 2;
            e.err   = (waits_of(a) >= TO);
            e.rdata = e.err ? 32'h0 : init_word(a);
            i_q.push_back(e);
            mif.i_addr = a;
            mif.i_req  = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                got = mif.i_ack;
            end
            mif.i_req = 1'b0;
            if (!got) fail("i_ack_timeout");
        end
    endtask

    task automatic data_agent(input int n);
        logic [31:0] a, wd, cur;
        logic [3:0]  sel;
        int unsigned op;
        exp_t e;
        bit got;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            a   = 32'h1000 + (32'($urandom_range(0, 63)) << 2);
            op  = $urandom_range(0, 2);
            sel = 4'($urandom_range(1, 15));
            wd  = $urandom;
            e.err = (waits_of(a) >= TO);
            cur = dmodel.exists(a) ? dmodel[a] : init_word(a);
            if (op == 0) begin
                e.rdata = e.err ? 32'h0 : cur;
            end else begin
                e.rdata = 32'h0;
                if (!e.err) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) cur[8*b +: 8] = wd[8*b +: 8];
                    dmodel[a] = cur;
                end
            end
            d_q.push_back(e);
            mif.d_addr  = a;
            mif.d_sel   = sel;
            mif.d_wdata = wd;
            mif.d_ren   = (op != 1);
            mif.d_wen   = (op != 0);
            got = 1'b0;
            for (int c = 0; c < 300 && !got; c++) begin
                @(negedge clk);
                got = mif.d_ack;
            end
            mif.d_ren = 1'b0;
            mif.d_wen = 1'b0;
            if (!got) fail("d_ack_timeout");
        end
    endtask

    initial begin
        mif.i_req = 1'b0; mif.i_addr = '0;
        mif.d_ren = 1'b0; mif.d_wen = 1'b0; mif.d_addr = '0; mif.d_wdata = '0; mif.d_sel = '0;
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", {mif.bus_ren, mif.bus_wen, mif.i_ack, mif.d_ack, mif.err, mif.bus_sel}, 64'h0);
        check("rst_bus", {mif.bus_addr, mif.bus_wdata}, 64'h0);
        check("rst_rdata", {mif.i_rdata, mif.d_rdata}, 64'h0);
        nrst = 1'b1;

        // Fetch with no wait states.
        mif.i_req = 1'b1; mif.i_addr = 32'h4; dir_busy = 1'b0; dir_rdata = 32'h3E80_0093;
        tick();
        check("fetch_bus", {mif.bus_ren, mif.bus_wen, mif.bus_sel, mif.bus_addr, mif.i_ack},
              {1'b1, 1'b0, 4'hF, 32'h4, 1'b0});
        tick();
        check("fetch_ack", {mif.i_ack, mif.err, mif.i_rdata}, {1'b1, 1'b0, 32'h3E80_0093});
        mif.i_req = 1'b0;
        tick();
        check("fetch_idle", {mif.i_ack, mif.bus_ren, mif.bus_sel}, 64'h0);

        // Store (with load also raised) and three wait states.
        mif.d_wen = 1'b1; mif.d_ren = 1'b1; mif.d_addr = 32'h100; mif.d_wdata = 32'h3E9; mif.d_sel = 4'h3;
        dir_busy = 1'b1; dir_rdata = 32'hDEAD_BEEF;
        tick();
        check("store_bus", {mif.bus_ren, mif.bus_wen, mif.bus_sel, mif.bus_addr},
              {1'b0, 1'b1, 4'h3, 32'h100});
        check("store_wdata", 64'(mif.bus_wdata), 64'h3E9);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("store_wait", {mif.bus_wen, mif.d_ack}, {1'b1, 1'b0});
        end
        dir_busy = 1'b0;
        tick();
        check("store_ack", {mif.d_ack, mif.err, mif.bus_wen, mif.d_rdata}, {1'b1, 1'b0, 1'b0, 32'h0});
        mif.d_wen = 1'b0; mif.d_ren = 1'b0;
        tick();

        // Contention right after reset: fetch, then data, then fetch again.
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        mif.i_req = 1'b1; mif.i_addr = 32'h8; mif.d_ren = 1'b1; mif.d_addr = 32'h200;
        dir_busy = 1'b0; dir_rdata = 32'h1111_2222;
        tick();
        check("cont_first_fetch", {mif.bus_ren, mif.bus_addr}, {1'b1, 32'h8});
        tick();
        check("cont_i_ack", {mif.i_ack, mif.d_ack}, {1'b1, 1'b0});
        mif.i_req = 1'b0;
        tick();
        check("cont_then_data", {mif.bus_ren, mif.bus_addr}, {1'b1, 32'h200});
        tick();
        check("cont_d_ack", {mif.i_ack, mif.d_ack, mif.d_rdata}, {1'b0, 1'b1, 32'h1111_2222});
        mif.d_ren = 1'b0;
        tick();
        mif.i_req = 1'b1; mif.d_ren = 1'b1;
        tick();
        check("cont_refetch", {mif.bus_ren, mif.bus_addr}, {1'b1, 32'h8});
        tick();
        check("cont_refetch_ack", {mif.i_ack, mif.d_ack}, {1'b1, 1'b0});
        mif.i_req = 1'b0; mif.d_ren = 1'b0;
        tick();

        // Load that never completes; requester also drops out mid-transaction.
        mif.d_ren = 1'b1; mif.d_addr = 32'h300; dir_busy = 1'b1; dir_rdata = 32'hFFFF_FFFF;
        tick();
        check("to_bus", {mif.bus_ren, mif.bus_addr}, {1'b1, 32'h300});
        mif.d_ren = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("to_wait", {mif.d_ack, mif.err, mif.bus_ren}, {1'b0, 1'b0, 1'b1});
        end
        tick();
        check("to_abort", {mif.d_ack, mif.err, mif.d_rdata}, {1'b1, 1'b1, 32'h0});
        tick();
        check("to_idle", {mif.d_ack, mif.err, mif.bus_ren}, 64'h0);

        // Reset in the middle of a stalled load.
        mif.d_ren = 1'b1; mif.d_addr = 32'h400; dir_busy = 1'b1;
        tick();
        check("rst_mid_bus", 64'(mif.bus_ren), 64'h1);
        #2 nrst = 1'b0;
        #1 check("rst_mid_async", {mif.bus_ren, mif.bus_addr}, 64'h0);
        mif.d_ren = 1'b0;
        @(negedge clk);
        check("rst_mid_no_ack", 64'(mif.d_ack), 64'h0);
        nrst = 1'b1;
        mif.i_req = 1'b1; mif.i_addr = 32'hC; dir_busy = 1'b0; dir_rdata = 32'h1234_5678;
        tick();
        check("rst_mid_fetch_bus", {mif.bus_ren, mif.bus_addr}, {1'b1, 32'hC});
        tick();
        check("rst_mid_fetch_ack", {mif.i_ack, mif.i_rdata}, {1'b1, 32'h1234_5678});
        mif.i_req = 1'b0;
        tick();

        // Random traffic against the wait-state memory.
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        auto_mem = 1'b1;
        rand_on  = 1'b1;
        @(negedge clk);
        fork
            fetch_agent(60);
            data_agent(60);
        join
        repeat (6) @(negedge clk);
        check("i_queue_drained", 64'(i_q.size()), 64'h0);
        check("d_queue_drained", 64'(d_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
